// File: rtl/distance_filter_pkg.sv
// Shared widths, FSM state type and sample struct for the distance filter.
// Also holds the clamp helper used on each converted quotient.
package distance_filter_pkg;
    localparam int RAW_W     = 22;
    localparam int CM_W      = 9;
    localparam int SUM_W     = 11;
    localparam int WIN_DEPTH = 4;
    localparam int PTR_W     = $clog2(WIN_DEPTH);
    localparam int DIV_W     = 12;
    localparam int STEP_W    = $clog2(RAW_W + 1);

    typedef enum logic [1:0] {IDLE, DIV, UPDATE} state_t;

    typedef struct packed {
        logic [CM_W-1:0] cm;
        logic            oor;
    } sample_t;

    function automatic sample_t clamp_cm(input logic [RAW_W-1:0] q,
                                         input logic [RAW_W-1:0] max_cm);
        sample_t s;
        s.oor = (q > max_cm);
        s.cm  = s.oor ? max_cm[CM_W-1:0] : q[CM_W-1:0];
        return s;
    endfunction
endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle, MSB first. The dividend register
// doubles as the quotient shift register; done flags the cycle of the final step.
module seq_divider
    import distance_filter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RAW_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             done,
    output logic [RAW_W-1:0] quotient
);
    logic [DIV_W-1:0]  rem;
    logic [DIV_W:0]    rem_sh;
    logic [STEP_W-1:0] step;
    logic              running;
    logic              fits;

    assign rem_sh = {rem, quotient[RAW_W-1]};
    assign fits   = (rem_sh >= {1'b0, divisor});
    assign done   = running && (step == STEP_W'(RAW_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient <= '0;
            rem      <= '0;
            step     <= '0;
            running  <= 1'b0;
        end else if (start) begin
            quotient <= dividend;
            rem      <= '0;
            step     <= '0;
            running  <= 1'b1;
        end else if (running) begin
            quotient <= {quotient[RAW_W-2:0], fits};
            // rem_sh - divisor is always below divisor, so it fits back in DIV_W bits
            rem      <= fits ? DIV_W'(rem_sh - {1'b0, divisor}) : rem_sh[DIV_W-1:0];
            step     <= step + 1'b1;
            if (done)
                running <= 1'b0;
        end
    end
endmodule

// File: rtl/distance_filter.sv
// Echo-count to centimetre converter with 4-sample moving average and a
// hysteresis near flag. One sample in flight; edges seen while busy are dropped.
module distance_filter
    import distance_filter_pkg::*;
#(
    parameter int CYCLES_PER_CM = 2900,
    parameter int MAX_CM        = 400,
    parameter int NEAR_CM       = 30,
    parameter int FAR_CM        = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ready,
    input  logic [RAW_W-1:0] distance_raw,
    output logic [CM_W-1:0]  distance_cm,
    output logic [CM_W-1:0]  avg_cm,
    output logic             out_of_range,
    output logic             near,
    output logic             out_valid,
    output logic             busy
);
    localparam logic [DIV_W-1:0] DIVISOR = DIV_W'(CYCLES_PER_CM);

    state_t                         state;
    logic                           ready_q, rise, div_start, div_done;
    logic [RAW_W-1:0]               quotient;
    logic [WIN_DEPTH-1:0][CM_W-1:0] win;
    logic [PTR_W-1:0]               ptr;
    logic [SUM_W-1:0]               sum, sum_nxt;
    logic [CM_W-1:0]                avg_nxt;
    logic                           near_nxt;
    sample_t                        smp;

    assign rise      = ready & ~ready_q;
    assign div_start = (state == IDLE) && rise;

    seq_divider u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (distance_raw),
        .divisor  (DIVISOR),
        .done     (div_done),
        .quotient (quotient)
    );

    // Oldest entry sits at the write pointer, so it is swapped out of the sum.
    assign smp     = clamp_cm(quotient, RAW_W'(MAX_CM));
    assign sum_nxt = sum - SUM_W'(win[ptr]) + SUM_W'(smp.cm);
    assign avg_nxt = CM_W'(sum_nxt >> 2);

    always_comb begin
        near_nxt = near;
        if (avg_nxt <= CM_W'(NEAR_CM))
            near_nxt = 1'b1;
        else if (avg_nxt >= CM_W'(FAR_CM))
            near_nxt = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ready_q      <= 1'b0;
            win          <= '0;
            ptr          <= '0;
            sum          <= '0;
            distance_cm  <= '0;
            avg_cm       <= '0;
            out_of_range <= 1'b0;
            near         <= 1'b0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            ready_q   <= ready;
            out_valid <= 1'b0;
            case (state)
                IDLE: if (rise) begin
                    state <= DIV;
                    busy  <= 1'b1;
                end
                DIV: if (div_done)
                    state <= UPDATE;
                UPDATE: begin
                    distance_cm  <= smp.cm;
                    out_of_range <= smp.oor;
                    avg_cm       <= avg_nxt;
                    near         <= near_nxt;
                    win[ptr]     <= smp.cm;
                    sum          <= sum_nxt;
                    ptr          <= ptr + 1'b1;
                    out_valid    <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_distance_filter.sv
// Directed + random bench for distance_filter against a sample-history model.
module tb_distance_filter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready = 1'b0;
    logic [21:0] distance_raw = '0;
    logic [8:0]  distance_cm, avg_cm;
    logic        out_of_range, near, out_valid, busy;

    int n_assert = 0;
    int n_fail   = 0;

    // model: full history of clamped samples since reset, seeded with four zeros
    int hist[$];
    bit m_near;

    distance_filter #(.CYCLES_PER_CM(2900), .MAX_CM(400), .NEAR_CM(30), .FAR_CM(40)) dut (
        .clk          (clk),
        .rst          (rst),
        .ready        (ready),
        .distance_raw (distance_raw),
        .distance_cm  (distance_cm),
        .avg_cm       (avg_cm),
        .out_of_range (out_of_range),
        .near         (near),
        .out_valid    (out_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist   = {0, 0, 0, 0};
        m_near = 1'b0;
    endtask

    task automatic model_push(input int raw, output int cm, output int oor, output int avg);
        int q, n;
        q   = raw / 2900;
        oor = (q > 400) ? 1 : 0;
        cm  = oor ? 400 : q;
        hist.push_back(cm);
        n   = hist.size();
        avg = (hist[n-1] + hist[n-2] + hist[n-3] + hist[n-4]) / 4;
        if (avg <= 30)      m_near = 1'b1;
        else if (avg >= 40) m_near = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cm"},   distance_cm,  0);
        check({tag, "_avg"},  avg_cm,       0);
        check({tag, "_oor"},  out_of_range, 0);
        check({tag, "_near"}, near,         0);
        check({tag, "_vld"},  out_valid,    0);
        check({tag, "_busy"}, busy,         0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_sample(input logic [21:0] raw);
        int k, e_cm, e_oor, e_avg;
        ready = 1'b0;
        @(negedge clk);
        distance_raw = raw;
        ready = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) check("busy_after_capture", busy, 1);
        end while (!out_valid && k < 40);
        model_push(int'(raw), e_cm, e_oor, e_avg);
        check("latency", k, 24);
        check("distance_cm", distance_cm, e_cm);
        check("out_of_range", out_of_range, e_oor);
        check("avg_cm", avg_cm, e_avg);
        check("near", near, m_near);
        check("busy_in_valid", busy, 0);
        ready = 1'b0;
        @(negedge clk);
        check("pulse_width", out_valid, 0);
    endtask

    initial begin
        int pulses, e_cm, e_oor, e_avg;
        int avg_tab[5];
        logic [21:0] raw_tab[5];
        logic [21:0] r;
        raw_tab = '{290000, 580000, 870000, 1160000, 0};
        avg_tab = '{25, 75, 150, 250, 225};

        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // conversion, truncation, zero, clamp
        run_sample(22'd29000);
        check("basic_cm", distance_cm, 10);
        run_sample(22'd2899);
        check("trunc_cm", distance_cm, 0);
        run_sample(22'd0);
        check("zero_cm", distance_cm, 0);
        run_sample(22'd4194303);
        check("clamp_cm", distance_cm, 400);
        check("clamp_oor", out_of_range, 1);

        // averaging ramp from a clean window
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_sample(raw_tab[i]);
            check("avg_ramp", avg_cm, avg_tab[i]);
        end

        // hysteresis: 30 sets, 35 holds, 40 clears, 35 holds
        repeat (4) run_sample(22'd87000);
        check("hyst_avg30", avg_cm, 30);
        check("hyst_set", near, 1);
        repeat (4) run_sample(22'd101500);
        check("hyst_avg35a", avg_cm, 35);
        check("hyst_hold1", near, 1);
        repeat (4) run_sample(22'd116000);
        check("hyst_avg40", avg_cm, 40);
        check("hyst_clear", near, 0);
        repeat (4) run_sample(22'd101500);
        check("hyst_avg35b", avg_cm, 35);
        check("hyst_hold0", near, 0);

        // random samples, mostly in the hysteresis-relevant range
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) r = 22'($urandom_range(0, 4194303));
            else                           r = 22'($urandom_range(0, 160000));
            run_sample(r);
        end

        // second edge while busy is dropped
        ready = 1'b0;
        @(negedge clk);
        distance_raw = 22'd145000;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        ready = 1'b0;
        repeat (2) @(negedge clk);
        distance_raw = 22'd300000;
        ready = 1'b1;
        model_push(145000, e_cm, e_oor, e_avg);
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                if (pulses == 1) begin
                    check("drop_cm", distance_cm, e_cm);
                    check("drop_avg", avg_cm, e_avg);
                end
            end
        end
        check("drop_pulses", pulses, 1);
        ready = 1'b0;
        @(negedge clk);

        // reset in the middle of the divide
        run_sample(22'd200000);
        ready = 1'b0;
        @(negedge clk);
        distance_raw = 22'd500000;
        ready = 1'b1;
        repeat (11) @(negedge clk);
        check("busy_mid_div", busy, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        ready = 1'b0;
        model_reset();
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("abort_no_valid", pulses, 0);
        run_sample(22'd290000);
        check("abort_window_clear", avg_cm, 25);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/distance_filter.md
# distance_filter

Converts raw ultrasonic echo counts from the proximity sensor into centimetres and smooths them with a 4-sample moving average. It sits directly downstream of the proximity sensor, consuming its `distance_raw`/`ready` pair. It raises a hysteresis-qualified `near` obstacle flag for the control logic and LED display. Conversion uses a sequential restoring divider, so the block accepts one sample at a time and signals completion with a one-cycle `out_valid` pulse.

## Interface
- `CYCLES_PER_CM`, default 2900: clk cycles of echo per cm (50 MHz, 58 µs/cm round trip); 12-bit, nonzero.
- `MAX_CM`, default 400: clamp ceiling for converted distance.
- `NEAR_CM`, default 30: `near` sets when average ≤ this.
- `FAR_CM`, default 40: `near` clears when average ≥ this. Must satisfy NEAR_CM < FAR_CM ≤ MAX_CM.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `ready`  in  1  level from the sensor; a 0→1 transition marks a new valid `distance_raw`.
- `distance_raw`  in  22  echo high-time in clk cycles.
- `distance_cm`  out  9  latest converted, clamped sample.
- `avg_cm`  out  9  moving average of the last 4 samples.
- `out_of_range`  out  1  latest sample exceeded MAX_CM before clamping.
- `near`  out  1  hysteresis obstacle flag.
- `out_valid`  out  1  one-cycle pulse when all outputs have updated.
- `busy`  out  1  high while a conversion is in progress.

## Operation
- Edge detect: register `ready` into `ready_q`. A rising edge is `ready & ~ready_q`.
- FSM states: IDLE, DIV, UPDATE.
  - IDLE: on rising edge, capture `distance_raw` as dividend, clear remainder and step counter, go to DIV.
  - DIV: 22 restoring steps, MSB first, one quotient bit per cycle. Go to UPDATE after step 22.
  - UPDATE: write outputs, return to IDLE.
- Quotient truncates toward zero. If quotient > MAX_CM: `distance_cm` = MAX_CM and `out_of_range` = 1; otherwise `out_of_range` = 0.
- Window: 4 × 9-bit entries in circular order with a 2-bit write pointer that wraps 3→0. Running sum is 11 bits and is updated as sum − oldest + new (max 1600, no overflow). `avg_cm` = sum >> 2 (truncating).
- Window entries reset to 0, so the average ramps up over the first 3 samples after reset. This is intended behaviour.
- `near` update, computed on the new `avg_cm`:
  - set if avg ≤ NEAR_CM;
  - clear if avg ≥ FAR_CM;
  - otherwise hold.
- Rising edges on `ready` while `busy` are dropped without queuing. `ready_q` keeps tracking, so a level still high at IDLE is not treated as a new edge.
- Reset values: all outputs 0, window/sum/pointer 0, FSM in IDLE, `ready_q` 0.
- Reset mid-conversion aborts immediately. No `out_valid` is produced and the partial result is discarded.

## Timing
- Capture edge = edge E0, at which IDLE sees the rising edge.
- `busy` goes high after E0.
- DIV occupies edges E1–E22. UPDATE registers outputs at edge E23.
- `out_valid` is high for exactly the cycle following E23. `busy` is low in that same cycle.
- A rising edge on `ready` in the `out_valid` cycle is accepted. Throughput is one sample per 24 cycles.
- Outputs are registered and hold between updates.

## Structure
- `distance_filter_pkg`: state enum (IDLE, DIV, UPDATE) and width constants RAW_W=22, CM_W=9, SUM_W=11, WIN_DEPTH=4.
- Sub-module `seq_divider`: restoring divider with 22-bit dividend, 12-bit divisor, and `start`/`done` handshake. The top FSM, window and hysteresis stay in `distance_filter`.

## Test plan
- Basic conversion: `distance_raw`=29000, raise `ready` → `out_valid` 24 cycles later, `distance_cm`=10, `out_of_range`=0.
- Truncation and zero: raw=2899 → `distance_cm`=0; raw=0 → `distance_cm`=0.
- Clamp: raw=4194303 (quotient 1446) → `distance_cm`=400, `out_of_range`=1.
- Averaging, four samples after reset:
  - raw 290000, 580000, 870000, 1160000;
  - `avg_cm` sequence 25, 75, 150, 250;
  - a fifth sample of 0 → `avg_cm`=225.
- Hysteresis:
  - drive the average to 30 → `near`=1;
  - average 35 → `near` stays 1;
  - average 40 → `near`=0;
  - average 35 → `near` stays 0.
- Busy drop and reset:
  - a second `ready` edge 5 cycles after the first produces no extra `out_valid`;
  - asserting `rst` at cycle 10 of DIV → all outputs 0 and no `out_valid`.
